// File: rtl/dq_data_path_pkg.sv
// Shared types and timing constants for the DQ data path and the scheduler.
// Holds the command/r_type enums, the column-command latencies and burst
// length used by both sides, the pending-queue entry layout, and the data-path
// FSM state encoding.
package dq_data_path_pkg;

  typedef enum logic [2:0] {
    none,
    activate,
    precharge,
    read_cmd,
    write_cmd,
    refresh_all
  } command;

  typedef enum logic {
    read_type,
    write_type
  } r_type;

  localparam int no_of_bursts = 4;
  localparam int rd_to_data   = 6;
  localparam int wr_to_data   = 5;
  localparam int burst_time   = 8;

  localparam int IDX_W = $clog2(no_of_bursts);
  localparam int CNT_W = $clog2((rd_to_data > wr_to_data ? rd_to_data : wr_to_data) + 1);

  typedef struct packed {
    r_type            typ;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] countdown;
  } pending_col_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BURST,
    READ_BURST
  } dp_state_t;

endpackage

// File: rtl/dq_data_path_col_cmd_queue.sv
// col_cmd_queue: FIFO of pending column commands. Every stored entry's
// countdown decrements once per cycle and saturates at zero.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i            store push_entry_i (accepted when not full, or when
//                     full and pop_i is high in the same cycle)
//   push_entry_i      entry to store
//   pop_i             remove the head entry
//   head_typ_o/idx_o  head entry fields
//   head_due_o        head's data window opens in the next cycle
//                     (countdown has reached 1, or 0 if it was held back)
//   full_o, empty_o   occupancy flags
module col_cmd_queue
  import dq_data_path_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  pending_col_t     push_entry_i,
  input  logic             pop_i,
  output r_type            head_typ_o,
  output logic [IDX_W-1:0] head_idx_o,
  output logic             head_due_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pending_col_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  // A pop frees the slot the push needs, so a full queue still accepts.
  assign push_ok    = push_i && (!full_o || pop_i);
  assign head_typ_o = mem_q[rptr_q].typ;
  assign head_idx_o = mem_q[rptr_q].idx;
  assign head_due_o = !empty_o && (mem_q[rptr_q].countdown <= CNT_W'(1));

  always_comb begin
    rptr_d  = pop_i   ? next_ptr(rptr_q) : rptr_q;
    wptr_d  = push_ok ? next_ptr(wptr_q) : wptr_q;
    count_d = count_q;
    if (push_ok && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset: occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i].countdown <= sat_dec(mem_q[i].countdown);
    end
    if (push_ok) begin
      mem_q[wptr_q] <= push_entry_i;
    end
  end

endmodule

// File: rtl/dq_data_path.sv
// dq_data_path: data-side responder to the command scheduler. Queues every
// read_cmd/write_cmd, then runs one burst at a time on the DQ bus: write
// bursts fetch beats from the burst buffers and drive dq_o, read bursts
// sample dq_i and return the beats tagged with their burst index.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_i, cmd_index_i         scheduler command and its burst index
//   wr_data_req_o/idx_o        write-beat request to a burst buffer
//   wr_data_i                  requested beat, one cycle after the request
//   dq_o, dq_oe_o              write data and output enable to the PHY
//   dq_i                       read data from the PHY
//   rd_valid_o/data_o/idx_o    returned read beat and destination burst
//   rd_last_o                  marks the last beat of a read burst
//   wr_done_o/idx_o            pulse after the last write beat
//   busy_o                     queue non-empty or burst active
//   err_o                      sticky: bit0 bus overlap, bit1 queue overflow
module dq_data_path
  import dq_data_path_pkg::*;
#(
  parameter int data_width  = 16,
  parameter int max_pending = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  command                cmd_i,
  input  logic [IDX_W-1:0]      cmd_index_i,
  output logic                  wr_data_req_o,
  output logic [IDX_W-1:0]      wr_data_idx_o,
  input  logic [data_width-1:0] wr_data_i,
  output logic [data_width-1:0] dq_o,
  output logic                  dq_oe_o,
  input  logic [data_width-1:0] dq_i,
  output logic                  rd_valid_o,
  output logic [data_width-1:0] rd_data_o,
  output logic [IDX_W-1:0]      rd_idx_o,
  output logic                  rd_last_o,
  output logic                  wr_done_o,
  output logic [IDX_W-1:0]      wr_done_idx_o,
  output logic                  busy_o,
  output logic [1:0]            err_o
);

  localparam int BEAT_W = (burst_time > 1) ? $clog2(burst_time) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(burst_time - 1);

  dp_state_t             state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [IDX_W-1:0]      cur_idx_q, cur_idx_d;

  logic                  is_wr_cmd, push;
  pending_col_t          push_entry;
  r_type                 head_typ;
  logic [IDX_W-1:0]      head_idx;
  logic                  head_due, q_full, q_empty;
  logic                  last_beat, start, overlap, overflow;

  logic                  rd_valid_q, rd_last_q, wr_done_q;
  logic [data_width-1:0] rd_data_q;
  logic [IDX_W-1:0]      rd_idx_q, wr_done_idx_q;
  logic [1:0]            err_q;

  // The entry must reach countdown 1 the cycle before its data window, which
  // is latency-1 cycles after it lands in the queue.
  assign is_wr_cmd  = (cmd_i == write_cmd);
  assign push       = is_wr_cmd || (cmd_i == read_cmd);
  assign push_entry = '{typ:       is_wr_cmd ? write_type : read_type,
                        idx:       cmd_index_i,
                        countdown: is_wr_cmd ? CNT_W'(wr_to_data - 1)
                                             : CNT_W'(rd_to_data - 1)};

  col_cmd_queue #(
    .DEPTH (max_pending)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (start),
    .head_typ_o   (head_typ),
    .head_idx_o   (head_idx),
    .head_due_o   (head_due),
    .full_o       (q_full),
    .empty_o      (q_empty)
  );

  assign last_beat = (state_q != IDLE) && (beat_q == BEAT_LAST);
  // A due head starts from IDLE, or chains onto the final beat with no gap.
  assign start     = head_due && ((state_q == IDLE) || last_beat);
  // Due while the bus is still busy: the transfer is held until the burst ends.
  assign overlap   = head_due && (state_q != IDLE) && !last_beat;
  assign overflow  = push && q_full && !start;

  // Stage: FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      cur_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cur_idx_q <= cur_idx_d;
    end
  end

  // Stage: FSM next state
  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    if (start) begin
      state_d   = (head_typ == write_type) ? WRITE_BURST : READ_BURST;
      cur_idx_d = head_idx;
    end else if (last_beat) begin
      state_d   = IDLE;
    end
    beat_d = ((state_q == IDLE) || last_beat) ? '0 : beat_q + 1'b1;
  end

  // Stage: FSM outputs (write side is combinational so the buffer beat
  // requested one cycle earlier goes straight onto the pins)
  always_comb begin
    wr_data_req_o = 1'b0;
    wr_data_idx_o = '0;
    if (start && (head_typ == write_type)) begin
      wr_data_req_o = 1'b1;
      wr_data_idx_o = head_idx;
    end else if ((state_q == WRITE_BURST) && !last_beat) begin
      wr_data_req_o = 1'b1;
      wr_data_idx_o = cur_idx_q;
    end
    dq_oe_o = (state_q == WRITE_BURST);
    dq_o    = dq_oe_o ? wr_data_i : '0;
  end

  // Stage: registered read return, write completion and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_idx_q      <= '0;
      rd_last_q     <= 1'b0;
      wr_done_q     <= 1'b0;
      wr_done_idx_q <= '0;
      err_q         <= '0;
    end else begin
      rd_valid_q    <= (state_q == READ_BURST);
      rd_data_q     <= (state_q == READ_BURST) ? dq_i : '0;
      rd_idx_q      <= (state_q == READ_BURST) ? cur_idx_q : '0;
      rd_last_q     <= (state_q == READ_BURST) && last_beat;
      wr_done_q     <= (state_q == WRITE_BURST) && last_beat;
      wr_done_idx_q <= ((state_q == WRITE_BURST) && last_beat) ? cur_idx_q : '0;
      err_q         <= err_q | {overflow, overlap};
    end
  end

  assign rd_valid_o    = rd_valid_q;
  assign rd_data_o     = rd_data_q;
  assign rd_idx_o      = rd_idx_q;
  assign rd_last_o     = rd_last_q;
  assign wr_done_o     = wr_done_q;
  assign wr_done_idx_o = wr_done_idx_q;
  assign err_o         = err_q;
  assign busy_o        = !q_empty || (state_q != IDLE);

endmodule

// File: tb/tb_dq_data_path.sv
// Self-checking bench for dq_data_path. A timeline model turns each accepted
// command into a scheduled burst (start = max(due, end of previous burst))
// and fills per-cycle expectation tables; every cycle the DUT outputs are
// compared against those tables. The bench also plays the burst buffers.
module tb_dq_data_path;
  import dq_data_path_pkg::*;

  localparam int DW = 16;
  localparam int MP = 4;
  localparam int IW = $clog2(no_of_bursts);
  localparam int BT = burst_time;
  localparam int NC = 2048;

  logic          clk;
  logic          rst_n;
  command        cmd_i;
  logic [IW-1:0] cmd_index_i;
  logic          wr_data_req_o;
  logic [IW-1:0] wr_data_idx_o;
  logic [DW-1:0] wr_data_i;
  logic [DW-1:0] dq_o;
  logic          dq_oe_o;
  logic [DW-1:0] dq_i;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic [IW-1:0] rd_idx_o;
  logic          rd_last_o;
  logic          wr_done_o;
  logic [IW-1:0] wr_done_idx_o;
  logic          busy_o;
  logic [1:0]    err_o;

  dq_data_path #(
    .data_width  (DW),
    .max_pending (MP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_i         (cmd_i),
    .cmd_index_i   (cmd_index_i),
    .wr_data_req_o (wr_data_req_o),
    .wr_data_idx_o (wr_data_idx_o),
    .wr_data_i     (wr_data_i),
    .dq_o          (dq_o),
    .dq_oe_o       (dq_oe_o),
    .dq_i          (dq_i),
    .rd_valid_o    (rd_valid_o),
    .rd_data_o     (rd_data_o),
    .rd_idx_o      (rd_idx_o),
    .rd_last_o     (rd_last_o),
    .wr_done_o     (wr_done_o),
    .wr_done_idx_o (wr_done_idx_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int cyc;

  bit e_req [NC];
  int e_widx[NC];
  bit e_oe  [NC];
  int e_dqo [NC];
  bit e_rv  [NC];
  int e_rsrc[NC];
  int e_ridx[NC];
  bit e_last[NC];
  bit e_done[NC];
  int e_didx[NC];
  bit e_busy[NC];
  int dq_hist[NC];

  int pend_q[$];
  int last_end;
  bit e_err0, e_err1;

  logic [DW-1:0] bufm [no_of_bursts][BT];
  int rp [no_of_bursts];
  bit last_req;
  int last_idx;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear(input int from);
    for (int i = from; i < NC; i++) begin
      e_req[i] = 0; e_oe[i] = 0; e_rv[i] = 0; e_last[i] = 0;
      e_done[i] = 0; e_busy[i] = 0;
    end
    pend_q.delete();
    last_end = 0;
    e_err0 = 0;
    e_err1 = 0;
    for (int b = 0; b < no_of_bursts; b++) rp[b] = 0;
  endtask

  // Command seen in cycle t: decide acceptance, then schedule its burst.
  task automatic model_accept(input command c, input int ix, input int t);
    int due, s, cnt;
    bit popping;
    if (c != read_cmd && c != write_cmd) return;
    while (pend_q.size() > 0 && pend_q[0] < t) void'(pend_q.pop_front());
    cnt = pend_q.size();
    popping = (cnt > 0) && (pend_q[0] == t);
    if (cnt >= MP && !popping) begin
      e_err1 = 1;
      return;
    end
    due = t + ((c == write_cmd) ? wr_to_data : rd_to_data);
    if (due < last_end) e_err0 = 1;
    s = (due > last_end) ? due : last_end;
    last_end = s + BT;
    pend_q.push_back(s - 1);
    for (int i = t + 1; i < s + BT; i++) e_busy[i] = 1;
    for (int j = 0; j < BT; j++) begin
      if (c == write_cmd) begin
        e_req[s-1+j] = 1;
        e_widx[s-1+j] = ix;
        e_oe[s+j] = 1;
        e_dqo[s+j] = int'(bufm[ix][j]);
      end else begin
        e_rv[s+1+j] = 1;
        e_rsrc[s+1+j] = s + j;
        e_ridx[s+1+j] = ix;
      end
    end
    if (c == write_cmd) begin
      e_done[s+BT] = 1;
      e_didx[s+BT] = ix;
    end else begin
      e_last[s+BT] = 1;
    end
  endtask

  task automatic check_cycle(input int c);
    chk_eq("wr_req", int'(wr_data_req_o), int'(e_req[c]));
    if (e_req[c]) chk_eq("wr_idx", int'(wr_data_idx_o), e_widx[c]);
    chk_eq("dq_oe", int'(dq_oe_o), int'(e_oe[c]));
    if (e_oe[c]) chk_eq("dq_o", int'(dq_o), e_dqo[c]);
    chk_eq("rd_valid", int'(rd_valid_o), int'(e_rv[c]));
    if (e_rv[c]) begin
      chk_eq("rd_data", int'(rd_data_o), dq_hist[e_rsrc[c]]);
      chk_eq("rd_idx", int'(rd_idx_o), e_ridx[c]);
    end
    chk_eq("rd_last", int'(rd_last_o), int'(e_last[c]));
    chk_eq("wr_done", int'(wr_done_o), int'(e_done[c]));
    if (e_done[c]) chk_eq("wr_done_idx", int'(wr_done_idx_o), e_didx[c]);
    chk_eq("busy", int'(busy_o), int'(e_busy[c]));
  endtask

  task automatic step(input command c, input int ix);
    @(posedge clk);
    cyc++;
    #1;
    if (last_req) begin
      wr_data_i = bufm[last_idx][rp[last_idx]];
      rp[last_idx] = (rp[last_idx] + 1) % BT;
    end else begin
      wr_data_i = DW'($urandom);
    end
    dq_i = DW'($urandom);
    dq_hist[cyc] = int'(dq_i);
    cmd_i = c;
    cmd_index_i = IW'(ix);
    model_accept(c, ix, cyc);
    @(negedge clk);
    check_cycle(cyc);
    last_req = wr_data_req_o;
    last_idx = int'(wr_data_idx_o);
  endtask

  task automatic idle(input int n);
    repeat (n) step(none, 0);
  endtask

  task automatic check_err();
    chk_eq("err", int'(err_o), int'({e_err1, e_err0}));
  endtask

  task automatic mid_reset();
    @(posedge clk);
    cyc++;
    #2;
    chk_eq("pre_rst_oe", int'(dq_oe_o), int'(e_oe[cyc]));
    rst_n = 1'b0;
    #1;
    chk_eq("rst_dq_oe", int'(dq_oe_o), 0);
    chk_eq("rst_busy", int'(busy_o), 0);
    chk_eq("rst_err", int'(err_o), 0);
    chk_eq("rst_wr_req", int'(wr_data_req_o), 0);
    chk_eq("rst_rd_valid", int'(rd_valid_o), 0);
    chk_eq("rst_wr_done", int'(wr_done_o), 0);
    model_clear(cyc);
    cmd_i = none;
    last_req = 0;
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    command c;
    int r;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    last_req = 0;
    last_idx = 0;
    for (int b = 0; b < no_of_bursts; b++)
      for (int j = 0; j < BT; j++) bufm[b][j] = DW'($urandom);
    model_clear(0);
    rst_n = 1'b0;
    cmd_i = none;
    cmd_index_i = '0;
    wr_data_i = '0;
    dq_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_req", int'(wr_data_req_o), 0);
    chk_eq("reset_oe", int'(dq_oe_o), 0);
    chk_eq("reset_rv", int'(rd_valid_o), 0);
    chk_eq("reset_done", int'(wr_done_o), 0);
    chk_eq("reset_busy", int'(busy_o), 0);
    chk_eq("reset_err", int'(err_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // single write
    step(write_cmd, 2);
    idle(30);
    check_err();
    // single read
    step(read_cmd, 1);
    idle(30);
    check_err();
    // back-to-back reads, no gap, no error
    step(read_cmd, 0);
    idle(7);
    step(read_cmd, 3);
    idle(40);
    check_err();
    // overlap: read due during a write burst is deferred
    step(write_cmd, 0);
    idle(2);
    step(read_cmd, 1);
    idle(40);
    check_err();
    // overflow: five reads in a row into a four-deep queue
    for (int i = 0; i < 5; i++) step(read_cmd, i % no_of_bursts);
    idle(60);
    check_err();
    // asynchronous reset on write beat 3
    step(write_cmd, 2);
    idle(7);
    mid_reset();
    idle(20);
    check_err();

    // random command stream
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 15);
      case (r)
        0:       c = read_cmd;
        1:       c = write_cmd;
        2:       c = activate;
        3:       c = precharge;
        4:       c = refresh_all;
        default: c = none;
      endcase
      step(c, $urandom_range(0, no_of_bursts - 1));
    end
    idle(80);
    check_err();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
